// File: rtl/int_seq.sv
// Interrupt/reset entry sequencer: pushes PCH, PCL, SR onto the page-1 stack, sets I, loads PC from the vector.
// Latency: 5 busy cycles per interrupt (PUSH_PCH..VEC_HI), 6 after reset including S_RST.
// Backpressure: RDY=0 freezes state and holds ADDR/RW/DO; all load enables and seq_done are forced low.
module int_seq #(
  parameter logic [15:0] VEC_NMI = 16'hFFFA,
  parameter logic [15:0] VEC_RST = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ = 16'hFFFE
) (
  input  logic        clk2,
  input  logic        rst,
  input  logic        RDY,
  input  logic        instr_done,
  input  logic        brk_req,
  input  logic        irq_req,
  input  logic        nmi_req,
  input  logic [15:0] PC_CUR,
  input  logic [7:0]  SP_Q,
  input  logic [7:0]  SR_Q,
  input  logic [7:0]  DB_IN,
  output logic [15:0] ADDR,
  output logic [7:0]  DO,
  output logic        RW,
  output logic        SP_EN,
  output logic [7:0]  SP_D,
  output logic        SR_EN,
  output logic [7:0]  SR_D,
  output logic        PCL_LD,
  output logic        PCH_LD,
  output logic [7:0]  PC_D,
  output logic        busy,
  output logic        seq_done
);

  typedef enum logic [2:0] {
    S_RST, IDLE, PUSH_PCH, PUSH_PCL, PUSH_SR, VEC_LO, VEC_HI
  } state_t;

  typedef enum logic [1:0] {K_RST, K_NMI, K_IRQ, K_BRK} kind_t;

  state_t state;
  kind_t  kind;
  logic   nmi_lat;
  logic   nmi_prev;
  logic   nmi_edge;
  logic   take_nmi;
  logic [15:0] vec;
  logic   sp_en_raw, sr_en_raw, pcl_raw, pch_raw, done_raw;

  // The register-file data paths are fixed functions; only the enables are sequenced.
  assign SP_D = SP_Q - 8'd1;
  assign SR_D = SR_Q | 8'h04;
  assign PC_D = DB_IN;

  // NMI edge detect and the acceptance that consumes the latched request.
  assign nmi_edge = nmi_req & ~nmi_prev;
  assign take_nmi = RDY & (state == IDLE) & instr_done & nmi_lat;

  // Sequencer state, entry kind and NMI latch; a fresh NMI edge beats a coincident clear.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      state    <= S_RST;
      kind     <= K_RST;
      nmi_lat  <= 1'b0;
      nmi_prev <= 1'b0;
    end else begin
      nmi_prev <= nmi_req;
      if (nmi_edge) begin
        nmi_lat <= 1'b1;
      end else if (take_nmi) begin
        nmi_lat <= 1'b0;
      end
      if (RDY) begin
        case (state)
          S_RST:    state <= PUSH_PCH;
          IDLE: begin
            if (instr_done) begin
              if (nmi_lat) begin
                kind  <= K_NMI;
                state <= PUSH_PCH;
              end else if (brk_req) begin
                kind  <= K_BRK;
                state <= PUSH_PCH;
              end else if (irq_req && !SR_Q[2]) begin
                kind  <= K_IRQ;
                state <= PUSH_PCH;
              end
            end
          end
          PUSH_PCH: state <= PUSH_PCL;
          PUSH_PCL: state <= PUSH_SR;
          PUSH_SR:  state <= VEC_LO;
          VEC_LO:   state <= VEC_HI;
          VEC_HI:   state <= IDLE;
          default:  state <= IDLE;
        endcase
      end
    end
  end

  // Bus and enable decode from state/kind; reset entry walks the stack without writing.
  always_comb begin
    vec       = (kind == K_NMI) ? VEC_NMI : (kind == K_RST) ? VEC_RST : VEC_IRQ;
    ADDR      = 16'h0000;
    DO        = 8'h00;
    RW        = 1'b1;
    busy      = 1'b1;
    sp_en_raw = 1'b0;
    sr_en_raw = 1'b0;
    pcl_raw   = 1'b0;
    pch_raw   = 1'b0;
    done_raw  = 1'b0;
    case (state)
      IDLE: busy = 1'b0;
      PUSH_PCH: begin
        ADDR      = {8'h01, SP_Q};
        DO        = PC_CUR[15:8];
        RW        = (kind == K_RST);
        sp_en_raw = 1'b1;
      end
      PUSH_PCL: begin
        ADDR      = {8'h01, SP_Q};
        DO        = PC_CUR[7:0];
        RW        = (kind == K_RST);
        sp_en_raw = 1'b1;
      end
      PUSH_SR: begin
        ADDR      = {8'h01, SP_Q};
        DO        = {SR_Q[7:6], 1'b1, (kind == K_BRK), SR_Q[3:0]};
        RW        = (kind == K_RST);
        sp_en_raw = 1'b1;
        sr_en_raw = 1'b1;
      end
      VEC_LO: begin
        ADDR    = vec;
        pcl_raw = 1'b1;
      end
      VEC_HI: begin
        ADDR     = vec + 16'd1;
        pch_raw  = 1'b1;
        done_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // A stalled cycle must not commit anything to the register file.
  assign SP_EN    = sp_en_raw & RDY;
  assign SR_EN    = sr_en_raw & RDY;
  assign PCL_LD   = pcl_raw & RDY;
  assign PCH_LD   = pch_raw & RDY;
  assign seq_done = done_raw & RDY;

endmodule

// File: tb/tb_int_seq.sv
module tb_int_seq;

  logic        clk2 = 1'b0;
  logic        rst, RDY, instr_done, brk_req, irq_req, nmi_req;
  logic [15:0] PC_CUR;
  logic [7:0]  SP_Q, SR_Q, DB_IN;
  logic [15:0] ADDR;
  logic [7:0]  DO, SP_D, SR_D, PC_D;
  logic        RW, SP_EN, SR_EN, PCL_LD, PCH_LD, busy, seq_done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        busy;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        rw;
    logic        sp_en;
    logic        sr_en;
    logic        pcl;
    logic        pch;
    logic        done;
    logic [7:0]  sp_d;
    logic [7:0]  sr_d;
    logic [7:0]  pc_d;
  } obs_t;

  obs_t sb[$];
  obs_t exp_v, obs_v;

  int_seq dut (
    .clk2(clk2), .rst(rst), .RDY(RDY), .instr_done(instr_done),
    .brk_req(brk_req), .irq_req(irq_req), .nmi_req(nmi_req),
    .PC_CUR(PC_CUR), .SP_Q(SP_Q), .SR_Q(SR_Q), .DB_IN(DB_IN),
    .ADDR(ADDR), .DO(DO), .RW(RW), .SP_EN(SP_EN), .SP_D(SP_D),
    .SR_EN(SR_EN), .SR_D(SR_D), .PCL_LD(PCL_LD), .PCH_LD(PCH_LD),
    .PC_D(PC_D), .busy(busy), .seq_done(seq_done)
  );

  always #5 clk2 = ~clk2;

  // Vector ROM; everything else reads back a filler byte.
  function automatic logic [7:0] rd(input logic [15:0] a);
    case (a)
      16'hFFFA: rd = 8'h78;
      16'hFFFB: rd = 8'h56;
      16'hFFFC: rd = 8'h34;
      16'hFFFD: rd = 8'h12;
      16'hFFFE: rd = 8'hBC;
      16'hFFFF: rd = 8'h9A;
      default:  rd = 8'hEE;
    endcase
  endfunction

  assign DB_IN = rd(ADDR);

  function automatic obs_t observe();
    obs_t o;
    o.busy = busy;   o.addr = ADDR;   o.dout = DO;     o.rw = RW;
    o.sp_en = SP_EN; o.sr_en = SR_EN; o.pcl = PCL_LD;  o.pch = PCH_LD;
    o.done = seq_done; o.sp_d = SP_D; o.sr_d = SR_D;   o.pc_d = PC_D;
    return o;
  endfunction

  function automatic obs_t mk(input logic b, input logic [15:0] a, input logic [7:0] d,
                              input logic rw, input logic spe, input logic sre,
                              input logic pl, input logic ph, input logic dn,
                              input logic [7:0] sp, input logic [7:0] sr);
    obs_t o;
    o.busy = b;    o.addr = a;    o.dout = d;  o.rw = rw;
    o.sp_en = spe; o.sr_en = sre; o.pcl = pl;  o.pch = ph;
    o.done = dn;   o.sp_d = sp - 8'd1; o.sr_d = sr | 8'h04; o.pc_d = rd(a);
    return o;
  endfunction

  function automatic obs_t idle_e(input logic [7:0] sp, input logic [7:0] sr);
    return mk(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sp, sr);
  endfunction

  // Expected cycles of one full entry sequence (k: 0=RST 1=NMI 2=IRQ 3=BRK), then one IDLE cycle.
  task automatic push_seq(input int k, input logic [7:0] sp0, input logic [7:0] sr0,
                          input logic [15:0] pc, input logic stall);
    logic        w;
    logic [15:0] vec;
    logic [7:0]  s1, s2, s3, srp, sr1;
    w   = (k == 0);
    vec = (k == 1) ? 16'hFFFA : (k == 0) ? 16'hFFFC : 16'hFFFE;
    s1  = sp0 - 8'd1;
    s2  = sp0 - 8'd2;
    s3  = sp0 - 8'd3;
    sr1 = sr0 | 8'h04;
    srp = {sr0[7:6], 1'b1, (k == 3), sr0[3:0]};
    sb.push_back(mk(1'b1, {8'h01, sp0}, pc[15:8], w, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, sp0, sr0));
    sb.push_back(mk(1'b1, {8'h01, s1},  pc[7:0],  w, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, s1,  sr0));
    sb.push_back(mk(1'b1, {8'h01, s2},  srp,      w, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, s2,  sr0));
    sb.push_back(mk(1'b1, vec, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, s3, sr1));
    if (stall) begin
      repeat (3) sb.push_back(mk(1'b1, vec, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s3, sr1));
    end
    sb.push_back(mk(1'b1, vec + 16'd1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, s3, sr1));
    sb.push_back(idle_e(s3, sr1));
  endtask

  task automatic test_reset();
    SP_Q = 8'h00; SR_Q = 8'h00; PC_CUR = 16'hABCD;
    sb.push_back(mk(1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00));
    push_seq(0, 8'h00, 8'h00, 16'hABCD, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk2);
      exp_v = sb.pop_front();
      obs_v = observe();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL reset cyc%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (i == 0) rst = 1'b0;
      #1;
      if (SP_EN) SP_Q = SP_D;
      if (SR_EN) SR_Q = SR_D;
    end
  endtask

  task automatic test_irq();
    SP_Q = 8'hFF; SR_Q = 8'h20; PC_CUR = 16'h1234;
    instr_done = 1'b1; irq_req = 1'b1;
    push_seq(2, 8'hFF, 8'h20, 16'h1234, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk2);
      exp_v = sb.pop_front();
      obs_v = observe();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL irq cyc%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (i == 0) begin instr_done = 1'b0; irq_req = 1'b0; end
      #1;
      if (SP_EN) SP_Q = SP_D;
      if (SR_EN) SR_Q = SR_D;
    end
  endtask

  task automatic test_masked_irq();
    SP_Q = 8'hFF; SR_Q = 8'h24;
    instr_done = 1'b1; irq_req = 1'b1;
    repeat (3) sb.push_back(idle_e(8'hFF, 8'h24));
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk2);
      exp_v = sb.pop_front();
      obs_v = observe();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL masked_irq cyc%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (i == 2) begin instr_done = 1'b0; irq_req = 1'b0; end
      #1;
      if (SP_EN) SP_Q = SP_D;
      if (SR_EN) SR_Q = SR_D;
    end
  endtask

  task automatic test_brk();
    SP_Q = 8'hFF; SR_Q = 8'h20; PC_CUR = 16'h4567;
    instr_done = 1'b1; brk_req = 1'b1;
    push_seq(3, 8'hFF, 8'h20, 16'h4567, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk2);
      exp_v = sb.pop_front();
      obs_v = observe();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL brk cyc%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (i == 0) begin instr_done = 1'b0; brk_req = 1'b0; end
      #1;
      if (SP_EN) SP_Q = SP_D;
      if (SR_EN) SR_Q = SR_D;
    end
  endtask

  task automatic test_nmi_priority();
    SP_Q = 8'hFF; SR_Q = 8'h20; PC_CUR = 16'h2468;
    nmi_req = 1'b1; irq_req = 1'b1;
    sb.push_back(idle_e(8'hFF, 8'h20));
    push_seq(1, 8'hFF, 8'h20, 16'h2468, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk2);
      exp_v = sb.pop_front();
      obs_v = observe();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL nmi_priority cyc%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (i == 0) instr_done = 1'b1;
      if (i == 1) begin instr_done = 1'b0; irq_req = 1'b0; end
      #1;
      if (SP_EN) SP_Q = SP_D;
      if (SR_EN) SR_Q = SR_D;
    end
  endtask

  task automatic test_nmi_held();
    SP_Q = 8'hFF; SR_Q = 8'h24;
    instr_done = 1'b1;
    repeat (3) sb.push_back(idle_e(8'hFF, 8'h24));
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk2);
      exp_v = sb.pop_front();
      obs_v = observe();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL nmi_held cyc%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (i == 2) instr_done = 1'b0;
      #1;
      if (SP_EN) SP_Q = SP_D;
      if (SR_EN) SR_Q = SR_D;
    end
  endtask

  task automatic test_nmi_retake();
    SP_Q = 8'hFF; SR_Q = 8'h24; PC_CUR = 16'h1357;
    nmi_req = 1'b0;
    sb.push_back(idle_e(8'hFF, 8'h24));
    sb.push_back(idle_e(8'hFF, 8'h24));
    push_seq(1, 8'hFF, 8'h24, 16'h1357, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk2);
      exp_v = sb.pop_front();
      obs_v = observe();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL nmi_retake cyc%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (i == 0) nmi_req = 1'b1;
      if (i == 1) instr_done = 1'b1;
      if (i == 2) begin instr_done = 1'b0; nmi_req = 1'b0; end
      #1;
      if (SP_EN) SP_Q = SP_D;
      if (SR_EN) SR_Q = SR_D;
    end
  endtask

  task automatic test_stall();
    SP_Q = 8'hFF; SR_Q = 8'h20; PC_CUR = 16'h8001;
    instr_done = 1'b1; irq_req = 1'b1;
    push_seq(2, 8'hFF, 8'h20, 16'h8001, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk2);
      exp_v = sb.pop_front();
      obs_v = observe();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL stall cyc%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (i == 0) begin instr_done = 1'b0; irq_req = 1'b0; end
      if (i == 3) RDY = 1'b0;
      if (i == 6) RDY = 1'b1;
      #1;
      if (SP_EN) SP_Q = SP_D;
      if (SR_EN) SR_Q = SR_D;
    end
  endtask

  task automatic test_rst_mid();
    SP_Q = 8'hFF; SR_Q = 8'h20; PC_CUR = 16'hC0DE;
    instr_done = 1'b1; irq_req = 1'b1;
    sb.push_back(mk(1'b1, 16'h01FF, 8'hC0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h20));
    sb.push_back(mk(1'b1, 16'h01FE, 8'hDE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE, 8'h20));
    sb.push_back(mk(1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE, 8'h20));
    push_seq(0, 8'hFE, 8'h20, 16'hC0DE, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk2);
      exp_v = sb.pop_front();
      obs_v = observe();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL rst_mid cyc%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (i == 0) begin instr_done = 1'b0; irq_req = 1'b0; end
      if (i == 1) rst = 1'b1;
      if (i == 2) rst = 1'b0;
      #1;
      if (SP_EN) SP_Q = SP_D;
      if (SR_EN) SR_Q = SR_D;
    end
  endtask

  initial begin
    rst = 1'b1; RDY = 1'b1; instr_done = 1'b0; brk_req = 1'b0;
    irq_req = 1'b0; nmi_req = 1'b0; PC_CUR = 16'h0000;
    SP_Q = 8'h00; SR_Q = 8'h00;
    repeat (2) @(posedge clk2);
    test_reset();
    test_irq();
    test_masked_irq();
    test_brk();
    test_nmi_priority();
    test_nmi_held();
    test_nmi_retake();
    test_stall();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
